// File: rtl/rr_arb_ctl_pkg.sv
// rr_arb_ctl_pkg: shared FSM encoding and index helpers for the round-robin arbiter.
// Helpers work on 32-bit containers so any N up to MAX_N can use them.
package rr_arb_ctl_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Increment an index modulo n (n need not be a power of two).
  function automatic logic [31:0] inc_mod(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    if (idx >= (n - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

  // Binary index of the set bit in a one-hot vector; zero for an all-zero vector.
  function automatic logic [31:0] onehot_to_bin(input logic [MAX_N-1:0] v);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) begin
        idx = idx | 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_ctl_prio_pick.sv
// prio_pick: fixed-priority (LSB-first) one-hot picker with an "any bit set" flag.
module prio_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Isolate the lowest set bit: v & -v keeps only the least-significant one.
  always_comb begin
    onehot = vec & (~vec + N'(1));
    any    = |vec;
  end

endmodule

// File: rtl/rr_arb_ctl.sv
// rr_arb_ctl: registered round-robin arbiter with rotating priority pointer.
// Optional macro RR_ARB_HOLD_EN: the current owner keeps the grant while it
// keeps requesting; without it the arbiter re-arbitrates every cycle.
// Requires 2 <= N <= 32 and W = ceil(log2(N)).
module rr_arb_ctl
  import rr_arb_ctl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);

  arb_state_e     state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   grant_idx_q, grant_idx_d;
  logic           grant_vld_q, grant_vld_d;

  logic [N-1:0]   mask_s;
  logic [N-1:0]   masked_req_s;
  logic [N-1:0]   masked_oh_s;
  logic [N-1:0]   full_oh_s;
  logic           masked_any_s;
  logic           full_any_s;
  logic [N-1:0]   winner_s;
  logic [MAX_N-1:0] winner_ext_s;
  logic [31:0]    win_idx32_s;
  logic [31:0]    ptr_next32_s;
  logic           rearb_s;

  // Mask keeps requesters at or above the priority pointer for the first pass.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (W'(i) >= ptr_q);
    end
    masked_req_s = req & mask_s;
  end

  prio_pick #(.N(N)) u_pick_masked (
    .vec    (masked_req_s),
    .onehot (masked_oh_s),
    .any    (masked_any_s)
  );

  prio_pick #(.N(N)) u_pick_full (
    .vec    (req),
    .onehot (full_oh_s),
    .any    (full_any_s)
  );

  // Select the winner: masked pass takes precedence, unmasked pass wraps around.
  always_comb begin
    if (masked_any_s) begin
      winner_s = masked_oh_s;
    end else begin
      winner_s = full_oh_s;
    end
    winner_ext_s          = '0;
    winner_ext_s[N-1:0]   = winner_s;
    win_idx32_s           = onehot_to_bin(winner_ext_s);
    ptr_next32_s          = inc_mod(win_idx32_s, 32'(N));
  end

  // Decide whether this cycle may re-arbitrate.
  always_comb begin
    case (state_q)
      IDLE: rearb_s = 1'b1;
`ifdef RR_ARB_HOLD_EN
      BUSY: rearb_s = ~req[grant_idx_q];
`else
      BUSY: rearb_s = 1'b1;
`endif
      default: rearb_s = 1'b1;
    endcase
  end

  // Next-state and next-owner computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    if (rearb_s) begin
      if (full_any_s) begin
        grant_d     = winner_s;
        grant_idx_d = win_idx32_s[W-1:0];
        ptr_d       = ptr_next32_s[W-1:0];
        state_d     = BUSY;
      end else begin
        grant_d     = '0;
        state_d     = IDLE;
      end
    end else begin
      state_d = state_q;
    end
    grant_vld_d = |grant_d;
  end

  // State, pointer and owner registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign grant_vld = grant_vld_q;

endmodule

// File: tb/tb_rr_arb_ctl.sv
// tb_rr_arb_ctl: self-checking bench for rr_arb_ctl with N=4.
// Builds for either setting of RR_ARB_HOLD_EN and selects matching scenarios.
module tb_rr_arb_ctl;

  localparam int N = 4;
  localparam int W = 2;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [W-1:0] idx;
    logic         vld;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         grant_vld;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   hold_en;

  // Reference model state
  int           m_ptr;
  bit           m_busy;
  logic [N-1:0] m_grant;
  logic [W-1:0] m_idx;

  rr_arb_ctl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = 1'b0;
    m_grant = '0;
    m_idx   = '0;
    exp_q.delete();
  endtask

  // Behavioural round-robin: scan ptr, ptr+1, ... mod N; push the expected outputs.
  task automatic model_step(input logic [N-1:0] r);
    bit rearb;
    int w;
    rearb = !m_busy || !hold_en || !r[m_idx];
    if (rearb) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && r[j]) w = j;
      end
      if (w >= 0) begin
        m_grant = N'(1) << w;
        m_idx   = w[W-1:0];
        m_ptr   = (w + 1) % N;
        m_busy  = 1'b1;
      end else begin
        m_grant = '0;
        m_busy  = 1'b0;
      end
    end
    exp_q.push_back('{grant: m_grant, idx: m_idx, vld: |m_grant});
  endtask

  // Drive one request vector for one clock and leave time at #1 after the edge.
  task automatic drive(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if ({grant, grant_idx, grant_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got grant=%b idx=%0d vld=%b want 0000/0/0", grant, grant_idx, grant_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_step(4'b1111);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first got grant=%b want 0001", grant);
    end
    checks++;
    if ({grant, grant_idx, grant_vld} !== e) begin
      errors++;
      $display("FAIL reset_first_sb got %b/%0d/%b want %b/%0d/%b",
               grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1111);
      e = exp_q.pop_front();
      checks++;
      if (grant_idx !== 2'(i % 4)) begin
        errors++;
        $display("FAIL fair_seq[%0d] got idx=%0d want %0d", i, grant_idx, i % 4);
      end
      checks++;
      if ({grant, grant_idx, grant_vld} !== e) begin
        errors++;
        $display("FAIL fair_sb[%0d] got %b/%0d/%b want %b/%0d/%b",
                 i, grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] want [6];
    logic [N-1:0] stim [6];
    want = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    stim = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== want[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got grant=%b want %b", i, grant, want[i]);
      end
      checks++;
      if ({grant, grant_idx, grant_vld} !== e) begin
        errors++;
        $display("FAIL b2b_sb[%0d] got %b/%0d/%b want %b/%0d/%b",
                 i, grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110);
      e = exp_q.pop_front();
      checks++;
      if (grant !== 4'b0010) begin
        errors++;
        $display("FAIL hold[%0d] got grant=%b want 0010", i, grant);
      end
      checks++;
      if ({grant, grant_idx, grant_vld} !== e) begin
        errors++;
        $display("FAIL hold_sb[%0d] got %b/%0d/%b want %b/%0d/%b",
                 i, grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
      end
    end
    drive(4'b0100);
    e = exp_q.pop_front();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL hold_handoff got grant=%b want 0100", grant);
    end
    checks++;
    if ({grant, grant_idx, grant_vld} !== e) begin
      errors++;
      $display("FAIL hold_handoff_sb got %b/%0d/%b want %b/%0d/%b",
               grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] stim [4];
    logic [N-1:0] want [4];
    stim = '{4'b0100, 4'b0011, 4'b0100, 4'b1001};
    want = '{4'b0100, 4'b0001, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== want[i]) begin
        errors++;
        $display("FAIL wrap[%0d] got grant=%b want %b", i, grant, want[i]);
      end
      checks++;
      if ({grant, grant_idx, grant_vld} !== e) begin
        errors++;
        $display("FAIL wrap_sb[%0d] got %b/%0d/%b want %b/%0d/%b",
                 i, grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
      end
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    drive(4'b1000);
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_idx, grant_vld} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL idle_busy got %b/%0d/%b want 1000/3/1", grant, grant_idx, grant_vld);
    end
    drive(4'b0000);
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_idx, grant_vld} !== {4'b0000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL idle_drop got %b/%0d/%b want 0000/3/0", grant, grant_idx, grant_vld);
    end
    checks++;
    if ({grant, grant_idx, grant_vld} !== e) begin
      errors++;
      $display("FAIL idle_drop_sb got %b/%0d/%b want %b/%0d/%b",
               grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
    end
    drive(4'b0000);
    e = exp_q.pop_front();
    drive(4'b0100);
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_idx, grant_vld} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL idle_regrant got %b/%0d/%b want 0100/2/1", grant, grant_idx, grant_vld);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b1000);
    e = exp_q.pop_front();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL async_pre got grant=%b want 1000", grant);
    end
    @(negedge clk);
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, grant_idx, grant_vld} !== {4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_clear got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_vld);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    model_step(4'b1111);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL async_ptr0 got grant=%b want 0001", grant);
    end
    checks++;
    if ({grant, grant_idx, grant_vld} !== e) begin
      errors++;
      $display("FAIL async_sb got %b/%0d/%b want %b/%0d/%b",
               grant, grant_idx, grant_vld, e.grant, e.idx, e.vld);
    end
  endtask

  initial begin
`ifdef RR_ARB_HOLD_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    test_reset();
    if (hold_en) begin
      test_hold();
    end else begin
      test_fairness();
      test_back_to_back();
    end
    test_wrap();
    test_idle_return();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
